// File: rtl/uart_rx_frame.sv
// +----------------------------------------------------------------------------+
// | uart_rx_frame: oversampled UART receiver with start validation, optional   |
// | parity, 1/2 stop bits and break suppression.  Revision: 1.0                |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] C_STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          C_PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;
  logic                 ferr_now;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d      = rx;
    sync2_d      = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bcnt_d       = bcnt_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    ferr_now     = ferr_q;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        S_START: begin
          // A line that is high again at mid start bit was only a glitch
          if (cnt_q == C_CNT_MID) begin
            cnt_d   = '0;
            bcnt_d  = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == C_CNT_LAST) begin
            cnt_d   = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bcnt_q == C_DATA_LAST) begin
              bcnt_d  = '0;
              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == C_CNT_LAST) begin
            cnt_d   = '0;
            perr_d  = (^shreg_q) ^ rx_s ^ C_PAR_ODD;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == C_CNT_LAST) begin
            cnt_d    = '0;
            ferr_now = ferr_q | ~rx_s;
            ferr_d   = ferr_now;
            // Leave at the middle of the last stop bit so a following start edge is not missed
            if (bcnt_q == C_STOP_LAST) begin
              bcnt_d       = '0;
              data_d       = shreg_q;
              parity_err_d = (PARITY_EN != 0) ? perr_q : 1'b0;
              frame_err_d  = ferr_now;
              valid_d      = 1'b1;
              state_d      = ferr_now ? S_BREAK : S_IDLE;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// +----------------------------------------------------------------------------+
// | tb_uart_rx_frame: directed bench for 8N1, 8E1 and 7O2 receiver instances. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx_a, rx_b, rx_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic       valid_a, valid_b, valid_c;
  logic       perr_a, perr_b, perr_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       busy_a, busy_b, busy_c;

  int div = 1;
  int tdiv_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  int         vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
  logic [7:0] last_a = '0, prev_a = '0, last_b = '0;
  logic [6:0] last_c = '0;
  logic       lperr_a = 0, lferr_a = 0, lperr_b = 0, lferr_b = 0, lperr_c = 0, lferr_c = 0;

  uart_rx_frame #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_a), .data(data_a), .valid(valid_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a));

  uart_rx_frame #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_b), .data(data_b), .valid(valid_b),
    .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b));

  uart_rx_frame #(.OVERSAMPLE(8), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_c), .data(data_c), .valid(valid_c),
    .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c));

  always #5 clk = ~clk;

  // Tick strobe: one clk in every `div`, changed just after the edge
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tdiv_cnt == 0);
      tdiv_cnt = (tdiv_cnt + 1 >= div) ? 0 : tdiv_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      vcnt_a++; prev_a = last_a; last_a = data_a; lperr_a = perr_a; lferr_a = ferr_a;
    end
    if (valid_b === 1'b1) begin
      vcnt_b++; last_b = data_b; lperr_b = perr_b; lferr_b = ferr_b;
    end
    if (valid_c === 1'b1) begin
      vcnt_c++; last_c = data_c; lperr_c = perr_c; lferr_c = ferr_c;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    #2;
  endtask

  task automatic set_rx(input int lane, input logic b);
    case (lane)
      0: rx_a = b;
      1: rx_b = b;
      default: rx_c = b;
    endcase
  endtask

  task automatic send_serial(input int lane, input logic [15:0] bits, input int n, input int os);
    for (int i = 0; i < n; i++) begin
      set_rx(lane, bits[i]);
      wait_ticks(os);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop);
    send_serial(0, {6'b0, stop, d, 1'b0}, 10, 16);
  endtask

  task automatic send_b(input logic [7:0] d, input logic p, input logic stop);
    send_serial(1, {5'b0, stop, p, d, 1'b0}, 11, 16);
  endtask

  task automatic send_c(input logic [6:0] d, input logic p, input logic s1, input logic s2);
    send_serial(2, {5'b0, s2, s1, p, d, 1'b0}, 11, 8);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({data_a, valid_a, perr_a, ferr_a, busy_a} !== 12'h000) begin
      n_errors++; $display("FAIL reset_a: got %h expected %h", {data_a, valid_a, perr_a, ferr_a, busy_a}, 12'h000);
    end
    n_checks++;
    if ({data_c, valid_c, perr_c, ferr_c, busy_c} !== 11'h000) begin
      n_errors++; $display("FAIL reset_c: got %h expected %h", {data_c, valid_c, perr_c, ferr_c, busy_c}, 11'h000);
    end
    rst = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_basic;
    int n0;
    n0 = vcnt_a;
    send_a(8'hA5, 1'b1);
    wait_ticks(4);
    n_checks++;
    if (vcnt_a - n0 !== 1) begin
      n_errors++; $display("FAIL basic_valid_count: got %0d expected 1", vcnt_a - n0);
    end
    n_checks++;
    if ({last_a, lperr_a, lferr_a} !== {8'hA5, 2'b00}) begin
      n_errors++; $display("FAIL basic_frame: got data=%h perr=%b ferr=%b expected data=a5 perr=0 ferr=0", last_a, lperr_a, lferr_a);
    end
    n_checks++;
    if ({data_a, busy_a} !== {8'hA5, 1'b0}) begin
      n_errors++; $display("FAIL basic_hold_busy: got data=%h busy=%b expected data=a5 busy=0", data_a, busy_a);
    end
  endtask

  task automatic test_false_start;
    int n0;
    n0 = vcnt_a;
    rx_a = 1'b0;
    wait_ticks(5);
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_errors++; $display("FAIL false_start_busy_in_start: got %b expected 1", busy_a);
    end
    rx_a = 1'b1;
    wait_ticks(20);
    n_checks++;
    if ({busy_a, data_a} !== {1'b0, 8'hA5} || vcnt_a != n0) begin
      n_errors++; $display("FAIL false_start_abort: got busy=%b data=%h valids=%0d expected busy=0 data=a5 valids=0", busy_a, data_a, vcnt_a - n0);
    end
  endtask

  task automatic test_parity;
    int n0;
    n0 = vcnt_b;
    send_b(8'h3C, 1'b1, 1'b1);
    wait_ticks(4);
    n_checks++;
    if (vcnt_b - n0 !== 1 || {last_b, lperr_b, lferr_b} !== {8'h3C, 2'b10}) begin
      n_errors++; $display("FAIL parity_bad: got n=%0d data=%h perr=%b ferr=%b expected n=1 data=3c perr=1 ferr=0", vcnt_b - n0, last_b, lperr_b, lferr_b);
    end
    n_checks++;
    if (perr_b !== 1'b1) begin
      n_errors++; $display("FAIL parity_err_hold: got %b expected 1", perr_b);
    end
    send_b(8'h3C, 1'b0, 1'b1);
    wait_ticks(4);
    n_checks++;
    if (vcnt_b - n0 !== 2 || {last_b, lperr_b, lferr_b} !== {8'h3C, 2'b00}) begin
      n_errors++; $display("FAIL parity_good: got n=%0d data=%h perr=%b ferr=%b expected n=2 data=3c perr=0 ferr=0", vcnt_b - n0, last_b, lperr_b, lferr_b);
    end
    send_b(8'h07, 1'b1, 1'b1);
    wait_ticks(4);
    n_checks++;
    if ({last_b, lperr_b} !== {8'h07, 1'b0}) begin
      n_errors++; $display("FAIL parity_odd_ones: got data=%h perr=%b expected data=07 perr=0", last_b, lperr_b);
    end
  endtask

  task automatic test_frame_err;
    int n0;
    n0 = vcnt_a;
    send_a(8'h55, 1'b0);
    wait_ticks(40 * 16);
    n_checks++;
    if (vcnt_a - n0 !== 1 || {last_a, lferr_a} !== {8'h55, 1'b1}) begin
      n_errors++; $display("FAIL frame_err_once: got n=%0d data=%h ferr=%b expected n=1 data=55 ferr=1", vcnt_a - n0, last_a, lferr_a);
    end
    n_checks++;
    if ({busy_a, ferr_a} !== 2'b11) begin
      n_errors++; $display("FAIL frame_err_break: got busy=%b ferr=%b expected busy=1 ferr=1", busy_a, ferr_a);
    end
    rx_a = 1'b1;
    wait_ticks(32);
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_errors++; $display("FAIL break_release: got busy=%b expected 0", busy_a);
    end
    send_a(8'h12, 1'b1);
    wait_ticks(4);
    n_checks++;
    if (vcnt_a - n0 !== 2 || {last_a, lferr_a} !== {8'h12, 1'b0}) begin
      n_errors++; $display("FAIL frame_after_break: got n=%0d data=%h ferr=%b expected n=2 data=12 ferr=0", vcnt_a - n0, last_a, lferr_a);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = vcnt_a;
    send_a(8'h00, 1'b1);
    send_a(8'hFF, 1'b1);
    wait_ticks(4);
    n_checks++;
    if (vcnt_a - n0 !== 2 || {prev_a, last_a} !== 16'h00FF) begin
      n_errors++; $display("FAIL back_to_back: got n=%0d first=%h second=%h expected n=2 first=00 second=ff", vcnt_a - n0, prev_a, last_a);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    logic [7:0] d;
    d = 8'h81;
    n0 = vcnt_a;
    send_serial(0, {12'b0, d[2:0], 1'b0}, 4, 16);
    rx_a = d[3];
    wait_ticks(8);
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_errors++; $display("FAIL reset_mid_busy_before: got %b expected 1", busy_a);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({data_a, busy_a, valid_a} !== 10'h000) begin
      n_errors++; $display("FAIL reset_mid_async: got data=%h busy=%b valid=%b expected 00 0 0", data_a, busy_a, valid_a);
    end
    repeat (3) @(posedge clk);
    #2;
    rx_a = 1'b1;
    rst = 1'b0;
    wait_ticks(16);
    n_checks++;
    if (vcnt_a != n0) begin
      n_errors++; $display("FAIL reset_mid_no_valid: got %0d valids expected 0", vcnt_a - n0);
    end
    send_a(8'h81, 1'b1);
    wait_ticks(4);
    n_checks++;
    if (vcnt_a - n0 !== 1 || {last_a, data_a} !== 16'h8181) begin
      n_errors++; $display("FAIL reset_mid_next_frame: got n=%0d data=%h expected n=1 data=81", vcnt_a - n0, data_a);
    end
  endtask

  task automatic test_lane_c;
    int n0;
    n0 = vcnt_c;
    send_c(7'h2B, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);
    n_checks++;
    if (vcnt_c - n0 !== 1 || {last_c, lperr_c, lferr_c} !== {7'h2B, 2'b00}) begin
      n_errors++; $display("FAIL c_good: got n=%0d data=%h perr=%b ferr=%b expected n=1 data=2b perr=0 ferr=0", vcnt_c - n0, last_c, lperr_c, lferr_c);
    end
    send_c(7'h2B, 1'b0, 1'b1, 1'b0);
    rx_c = 1'b1;
    wait_ticks(16);
    n_checks++;
    if (vcnt_c - n0 !== 2 || {last_c, lperr_c, lferr_c} !== {7'h2B, 2'b11}) begin
      n_errors++; $display("FAIL c_second_stop: got n=%0d data=%h perr=%b ferr=%b expected n=2 data=2b perr=1 ferr=1", vcnt_c - n0, last_c, lperr_c, lferr_c);
    end
    n_checks++;
    if (busy_c !== 1'b0) begin
      n_errors++; $display("FAIL c_idle_after_break: got busy=%b expected 0", busy_c);
    end
  endtask

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    test_reset;
    test_basic;
    test_false_start;
    test_parity;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_lane_c;
    div = 4;
    wait_ticks(2);
    test_basic;
    test_false_start;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
